// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 4-digit BCD display scanner with a double-buffered word load.
// Slot timing is free-running in SCAN; blanking and bad digits only mask outputs.
//
//   state | meaning
//   OFF   | display dark, div/idx parked at 0, a pending word applies next cycle
//   SCAN  | cycling digit slots, a pending word applies at the frame boundary
module seg7_scan_ctrl #(
    parameter int SCAN_DIV = 1000,
    parameter bit LZB      = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic [3:0]  bcd,
    output logic [3:0]  dig_sel,
    output logic        frame_done,
    output logic        err
);

    localparam int DIV_W = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic {
        ST_OFF  = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_nxt;
    logic [15:0]      r_active;
    logic [15:0]      r_shadow;
    logic             r_pending;

    logic             w_tick;
    logic             w_frame_end;
    logic             w_accept;
    logic             w_apply;
    logic [3:0]       w_dig [4];
    logic [3:0]       w_bad;
    logic [3:0]       w_blank;
    logic [3:0]       w_show;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_OFF;
            r_div   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    assign w_tick = (r_state == ST_SCAN) && (r_div == DIV_LAST);
    // An enable drop abandons the slot, so the boundary needs enable still high.
    assign w_frame_end = w_tick && (r_idx == 2'd3) && enable;

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_OFF: begin
                w_div_nxt = '0;
                w_idx_nxt = '0;
                if (enable) begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!enable) begin
                    w_state_nxt = ST_OFF;
                    w_div_nxt   = '0;
                    w_idx_nxt   = '0;
                end else if (w_tick) begin
                    w_div_nxt = '0;
                    w_idx_nxt = r_idx + 2'd1;
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
                w_div_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign w_accept = in_valid && !r_pending;
    assign w_apply  = r_pending && ((r_state == ST_OFF) || w_frame_end);

    // accept and apply are mutually exclusive: one needs pending low, the other high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active  <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_apply) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end
            if (w_accept) begin
                r_shadow  <= in_data;
                r_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_dig[i] = r_active[4*i +: 4];
            w_bad[i] = (w_dig[i] > 4'd9);
        end
    end

    always_comb begin
        w_blank    = '0;
        w_blank[3] = LZB && (w_dig[3] == 4'd0);
        w_blank[2] = LZB && (w_dig[3] == 4'd0) && (w_dig[2] == 4'd0);
        w_blank[1] = LZB && (w_dig[3] == 4'd0) && (w_dig[2] == 4'd0) && (w_dig[1] == 4'd0);
        w_show     = ~w_bad & ~w_blank;
    end

    always_comb begin
        dig_sel = '0;
        bcd     = '0;
        if ((r_state == ST_SCAN) && w_show[r_idx]) begin
            dig_sel = 4'b0001 << r_idx;
            bcd     = w_dig[r_idx];
        end
    end

    assign frame_done = w_frame_end;
    assign err        = |w_bad;
    assign in_ready   = !r_pending;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: table of single-word frames plus
// hand-written load/enable/reset sequences, on LZB=0 and LZB=1 instances.
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        in_valid;
    logic [15:0] in_data;

    logic        rdy0, rdy1, fd0, fd1, err0, err1;
    logic [3:0]  bcd0, bcd1, ds0, ds1;

    logic        sel;
    logic [3:0]  s_ds, s_bcd;
    logic        s_fd, s_err, s_rdy;

    int n_checks;
    int n_fail;

    typedef struct packed {
        logic [15:0] word;
        logic        lzb;
        logic [15:0] ds_all;
        logic [15:0] bcd_all;
        logic        err;
    } vec_t;

    vec_t vecs [8];

    seg7_scan_ctrl #(.SCAN_DIV(4), .LZB(1'b0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .in_valid(in_valid),
        .in_data(in_data), .in_ready(rdy0), .bcd(bcd0), .dig_sel(ds0),
        .frame_done(fd0), .err(err0)
    );

    seg7_scan_ctrl #(.SCAN_DIV(4), .LZB(1'b1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .in_valid(in_valid),
        .in_data(in_data), .in_ready(rdy1), .bcd(bcd1), .dig_sel(ds1),
        .frame_done(fd1), .err(err1)
    );

    always_comb begin
        s_ds  = sel ? ds1  : ds0;
        s_bcd = sel ? bcd1 : bcd0;
        s_fd  = sel ? fd1  : fd0;
        s_err = sel ? err1 : err0;
        s_rdy = sel ? rdy1 : rdy0;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset(input string nm);
        reset_n  = 1'b0;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        @(negedge clk);
        cmp({nm, "_rst_ds"},  16'(s_ds),  16'h0);
        cmp({nm, "_rst_bcd"}, 16'(s_bcd), 16'h0);
        cmp({nm, "_rst_fd"},  16'(s_fd),  16'h0);
        cmp({nm, "_rst_err"}, 16'(s_err), 16'h0);
        cmp({nm, "_rst_rdy"}, 16'(s_rdy), 16'h1);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Called at a negedge in OFF; returns at a negedge with the word applied.
    task automatic load_off(input logic [15:0] w);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_scan();
        enable = 1'b1;
        @(posedge clk);
    endtask

    // Samples k0..k1 of a frame (k = 4*slot + cycle-in-slot).
    task automatic chk_span(input string nm, input logic [15:0] ds_all, input logic [15:0] bcd_all,
                            input int k0, input int k1, input bit do_rdy, input logic exp_rdy);
        for (int k = k0; k <= k1; k++) begin
            int s;
            s = k / 4;
            @(negedge clk);
            cmp($sformatf("%s_k%0d_ds", nm, k),  16'(s_ds),  16'(ds_all[4*s +: 4]));
            cmp($sformatf("%s_k%0d_bcd", nm, k), 16'(s_bcd), 16'(bcd_all[4*s +: 4]));
            cmp($sformatf("%s_k%0d_fd", nm, k),  16'(s_fd),  16'(k == 15));
            if (do_rdy) cmp($sformatf("%s_k%0d_rdy", nm, k), 16'(s_rdy), 16'(exp_rdy));
        end
    endtask

    task automatic chk_off(input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cmp($sformatf("%s_%0d_ds", nm, i),  16'(s_ds),  16'h0);
            cmp($sformatf("%s_%0d_bcd", nm, i), 16'(s_bcd), 16'h0);
            cmp($sformatf("%s_%0d_fd", nm, i),  16'(s_fd),  16'h0);
            cmp($sformatf("%s_%0d_rdy", nm, i), 16'(s_rdy), 16'h1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sel      = 1'b0;
        reset_n  = 1'b0;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'h0000;

        //            word      lzb   ds {s3,s2,s1,s0}  bcd {s3..s0}  err
        vecs[0] = '{16'h1234, 1'b0, 16'h8421, 16'h1234, 1'b0};
        vecs[1] = '{16'h0070, 1'b1, 16'h0021, 16'h0070, 1'b0};
        vecs[2] = '{16'h12A4, 1'b0, 16'h8401, 16'h1204, 1'b1};
        vecs[3] = '{16'h0000, 1'b1, 16'h0001, 16'h0000, 1'b0};
        vecs[4] = '{16'h0000, 1'b0, 16'h8421, 16'h0000, 1'b0};
        vecs[5] = '{16'h9F09, 1'b1, 16'h8021, 16'h9009, 1'b1};
        vecs[6] = '{16'h0305, 1'b1, 16'h0421, 16'h0305, 1'b0};
        vecs[7] = '{16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b1};

        for (int v = 0; v < 8; v++) begin
            sel = vecs[v].lzb;
            do_reset($sformatf("v%0d", v));
            load_off(vecs[v].word);
            cmp($sformatf("v%0d_err", v), 16'(s_err), 16'(vecs[v].err));
            cmp($sformatf("v%0d_off_ds", v), 16'(s_ds), 16'h0);
            start_scan();
            chk_span($sformatf("v%0d_f0", v), vecs[v].ds_all, vecs[v].bcd_all, 0, 15, 1'b1, 1'b1);
            chk_span($sformatf("v%0d_f1", v), vecs[v].ds_all, vecs[v].bcd_all, 0, 3, 1'b0, 1'b0);
        end

        // Mid-frame load held off to the boundary; in_valid held high across it.
        sel = 1'b0;
        do_reset("A");
        load_off(16'h1234);
        start_scan();
        chk_span("A_pre", 16'h8421, 16'h1234, 0, 5, 1'b1, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'h5678;
        chk_span("A_acc", 16'h8421, 16'h1234, 6, 6, 1'b1, 1'b0);
        in_data  = 16'h1111;
        chk_span("A_old", 16'h8421, 16'h1234, 7, 15, 1'b1, 1'b0);
        chk_span("A_new", 16'h8421, 16'h5678, 0, 0, 1'b1, 1'b1);
        chk_span("A_new", 16'h8421, 16'h5678, 1, 1, 1'b1, 1'b0);
        in_valid = 1'b0;
        chk_span("A_new", 16'h8421, 16'h5678, 2, 15, 1'b1, 1'b0);
        chk_span("A_nxt", 16'h8421, 16'h1111, 0, 15, 1'b1, 1'b1);

        // Enable dropped in slot 2, then restarted from slot 0.
        do_reset("B");
        load_off(16'h1234);
        start_scan();
        chk_span("B_pre", 16'h8421, 16'h1234, 0, 9, 1'b0, 1'b0);
        enable = 1'b0;
        chk_off("B_off", 4);
        start_scan();
        chk_span("B_re", 16'h8421, 16'h1234, 0, 15, 1'b1, 1'b1);

        // Asynchronous reset mid-slot with a word pending.
        do_reset("C");
        load_off(16'h1234);
        start_scan();
        chk_span("C_pre", 16'h8421, 16'h1234, 0, 5, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h5678;
        chk_span("C_acc", 16'h8421, 16'h1234, 6, 6, 1'b1, 1'b0);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        cmp("C_async_ds",  16'(s_ds),  16'h0);
        cmp("C_async_bcd", 16'(s_bcd), 16'h0);
        cmp("C_async_fd",  16'(s_fd),  16'h0);
        cmp("C_async_err", 16'(s_err), 16'h0);
        cmp("C_async_rdy", 16'(s_rdy), 16'h1);
        enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk_off("C_wait", 3);
        start_scan();
        chk_span("C_blank", 16'h8421, 16'h0000, 0, 15, 1'b1, 1'b1);

        // Error word replaced mid-frame; err clears only at the boundary.
        do_reset("D");
        load_off(16'h12A4);
        start_scan();
        chk_span("D_bad", 16'h8401, 16'h1204, 0, 0, 1'b1, 1'b1);
        cmp("D_err_set", 16'(s_err), 16'h1);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        chk_span("D_bad", 16'h8401, 16'h1204, 1, 1, 1'b1, 1'b0);
        in_valid = 1'b0;
        chk_span("D_bad", 16'h8401, 16'h1204, 2, 15, 1'b1, 1'b0);
        cmp("D_err_hold", 16'(s_err), 16'h1);
        chk_span("D_good", 16'h8421, 16'h1234, 0, 0, 1'b1, 1'b1);
        cmp("D_err_clr", 16'(s_err), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter SCAN_DIV, default 1000: clk cycles per digit slot, minimum 2.
REQ-003 Parameter LZB, default 1: 1 blanks leading zeros, 0 disables blanking.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 enable  input  1  1 = scan display, 0 = display off.
REQ-007 in_valid  input  1  in_data holds a new 4-digit BCD word.
REQ-008 in_data  input  16  digit3 in [15:12] down to digit0 in [3:0].
REQ-009 in_ready  output  1  block can accept a word.
REQ-010 bcd  output  4  digit code driven to the shared seg7 decoder.
REQ-011 dig_sel  output  4  one-hot active-high digit enable; bit i selects digit i.
REQ-012 frame_done  output  1  one-cycle pulse at the end of each 4-digit frame.
REQ-013 err  output  1  the active word contains a non-BCD digit (>9).

Function
REQ-014 State machine states SHALL be OFF and SCAN; reset enters OFF.
REQ-015 In OFF with enable=1, the next state SHALL be SCAN, with idx=0 and div=0.
REQ-016 In SCAN with enable=0, the next state SHALL be OFF; the current slot is abandoned and no frame_done is issued.
REQ-017 In SCAN, div SHALL count 0..SCAN_DIV-1; tick = (div==SCAN_DIV-1); div wraps to 0 on tick.
REQ-018 On tick, idx SHALL advance modulo 4 (3 -> 0 wrap); frame_done SHALL pulse in the cycle where tick and idx==3 coincide.
REQ-019 In OFF, dig_sel SHALL be 0, bcd 0, frame_done 0, and div/idx held at 0.
REQ-020 In SCAN, dig_sel SHALL be 1<<idx and bcd SHALL be active[4*idx+3:4*idx], both derived only from registers with no combinational path from inputs.
REQ-021 Handshake: a word transfers when in_valid && in_ready; in_ready = !pending; a transfer writes shadow and sets pending.
REQ-022 pending SHALL be applied (active <= shadow, pending <= 0) on the frame boundary (frame_done cycle) in SCAN, or on the cycle after acceptance in OFF, so a frame never shows mixed words.
REQ-023 When a frame boundary and in_valid coincide while pending=1, the word SHALL NOT be accepted; acceptance becomes possible from the next cycle.
REQ-024 in_data SHALL be ignored when in_valid=0 or in_ready=0; in_valid held high SHALL NOT cause a second transfer until pending clears.
REQ-025 A digit >9 SHALL be driven as bcd=0 with its dig_sel bit forced to 0 for that slot; err = OR over the four active digits of (digit>9).
REQ-026 With LZB=1, digit i (i=3..1) SHALL be blanked (dig_sel bit 0, bcd 0) when it and all higher digits are zero; digit 0 is never blanked; the slot timing is unchanged.
REQ-027 Slot timing SHALL be independent of blanking, errors and loads: each slot is exactly SCAN_DIV cycles.

Reset
REQ-028 reset_n=0 SHALL immediately force: state OFF, div=0, idx=0, active=0, shadow=0, pending=0, dig_sel=0, bcd=0, frame_done=0, err=0, in_ready=1.
REQ-029 Reset asserted mid-slot or with pending=1 SHALL discard the pending word; after release, the block waits in OFF for enable.

Verification
REQ-030 SCAN_DIV=4, LZB=0, load 0x1234, enable=1 -> dig_sel 0001/bcd 4, 0010/3, 0100/2, 1000/1, each 4 cycles; frame_done pulses once per 16 cycles.
REQ-031 Load 0x5678 mid-frame while 0x1234 is displayed -> in_ready=0 until the frame boundary; the first full frame afterwards shows 8,7,6,5; no frame mixes digits.
REQ-032 LZB=1, load 0x0070 -> digits 3 and 2 blanked (dig_sel 0 in slots 3 and 2), slot 1 shows 7, slot 0 shows 0; frame period remains 4*SCAN_DIV.
REQ-033 Load 0x12A4 -> err=1, slot 1 shows dig_sel=0/bcd=0, other slots correct; a later load of 0x1234 clears err at the frame boundary.
REQ-034 enable dropped in slot 2 -> OFF next cycle (dig_sel=0, no frame_done); enable re-raised -> restart at idx 0 with full-length slots.
REQ-035 reset_n pulsed low asynchronously mid-slot with pending=1 -> outputs go to reset values without waiting for a clk edge; pending is cleared and in_ready=1.
